// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_pkg
// Purpose  : Shared definitions for the L2 cache. Holds the controller state
//            encoding, the default line and address widths, and a helper that
//            derives the tag width from the address and index widths.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package l2_pkg;

   localparam int LINE_W_DEF = 128;
   localparam int ADDR_W_DEF = 28;
   localparam int IDX_W_DEF  = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COMPARE   = 3'd1,
      ST_WRITEBACK = 3'd2,
      ST_ALLOCATE  = 3'd3,
      ST_RESPOND   = 3'd4
   } state_e;

   function automatic int tag_width(input int addr_w, input int idx_w);
      return addr_w - idx_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_line_store.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_store
// Purpose  : Tag / valid / dirty / data storage for the direct-mapped L2.
//            Valid and dirty bits clear asynchronously on reset; tag and data
//            arrays are not reset (they are meaningless while valid is 0).
// Ports    : clk, rst_n            - clock, async active-low reset
//            rd_idx                - combinational read index
//            rd_valid/dirty/tag/line - entry contents at rd_idx
//            wr_idx                - write index
//            wr_line_en, wr_line   - replace the data line
//            wr_tag_en, wr_tag     - install a tag and mark the entry valid
//            wr_dirty_en, wr_dirty - update the dirty bit
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module l2_line_store #(
   parameter int LINE_W = 128,
   parameter int IDX_W  = 3,
   parameter int TAG_W  = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic              wr_line_en,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              wr_tag_en,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic              wr_dirty_en,
   input  logic              wr_dirty
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ENTRIES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]   tag_q  [ENTRIES];
   logic [TAG_W-1:0]   tag_d  [ENTRIES];
   logic [LINE_W-1:0]  data_q [ENTRIES];
   logic [LINE_W-1:0]  data_d [ENTRIES];

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_line  = data_q[rd_idx];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_line_en) begin
         data_d[wr_idx] = wr_line;
      end
      // Installing a tag is the only way an entry becomes valid.
      if (wr_tag_en) begin
         tag_d[wr_idx]   = wr_tag;
         valid_d[wr_idx] = 1'b1;
      end
      if (wr_dirty_en) begin
         dirty_d[wr_idx] = wr_dirty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule
`default_nettype wire

// File: rtl/l2_cache.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache
// Purpose  : Direct-mapped, write-back, write-allocate second-level cache.
//            Responder to the L1 line interface, initiator to main memory.
//            Whole 128-bit lines are transferred; all outputs are registered.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            read, write, addr, wdata   - L1 request (held until ready)
//            rdata, ready               - L1 response (ready is a 1-cycle pulse)
//            mem_read, mem_write, mem_addr, mem_wdata - memory request
//            mem_rdata, mem_ready       - memory response
//            hit_cnt, miss_cnt          - saturating statistics (L2_STAT_EN)
// Options  : L2_STAT_EN - adds hit/miss counters and their output ports
// Revision : 1.0 - initial release
// ============================================================================
module l2_cache
   import l2_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata,
   output logic              ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
`ifdef L2_STAT_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int TAG_W = tag_width(ADDR_W, IDX_W);

   state_e              state_q, state_d;
   logic                op_wr_q, op_wr_d;
   logic                ready_q, ready_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic                rd_valid, rd_dirty, hit;
   logic [TAG_W-1:0]    rd_tag;
   logic [LINE_W-1:0]   rd_line;
   logic                st_line_en, st_tag_en, st_dirty_en, st_dirty;
   logic [LINE_W-1:0]   st_line;

   assign idx = addr[IDX_W-1:0];
   assign tag = addr[ADDR_W-1:IDX_W];
   assign hit = rd_valid && (rd_tag == tag);

   l2_line_store #(
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
   ) u_store (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx      (idx),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_tag      (rd_tag),
      .rd_line     (rd_line),
      .wr_idx      (idx),
      .wr_line_en  (st_line_en),
      .wr_line     (st_line),
      .wr_tag_en   (st_tag_en),
      .wr_tag      (tag),
      .wr_dirty_en (st_dirty_en),
      .wr_dirty    (st_dirty)
   );

   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      ready_d     = 1'b0;
      rdata_d     = rdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      st_line_en  = 1'b0;
      st_tag_en   = 1'b0;
      st_dirty_en = 1'b0;
      st_dirty    = 1'b0;
      st_line     = wdata;
      unique case (state_q)
         ST_IDLE: begin
            if (read || write) begin
               op_wr_d = write;          // write wins over a simultaneous read
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (hit) begin
               if (op_wr_q) begin
                  st_line_en  = 1'b1;
                  st_dirty_en = 1'b1;
                  st_dirty    = 1'b1;
               end else begin
                  rdata_d = rd_line;
               end
               ready_d = 1'b1;
               state_d = ST_RESPOND;
            end else if (rd_valid && rd_dirty) begin
               mem_write_d = 1'b1;
               mem_addr_d  = {rd_tag, idx};
               mem_wdata_d = rd_line;
               state_d     = ST_WRITEBACK;
            end else if (op_wr_q) begin
               // Full-line write over a clean victim: no fetch needed.
               st_line_en  = 1'b1;
               st_tag_en   = 1'b1;
               st_dirty_en = 1'b1;
               st_dirty    = 1'b1;
               ready_d     = 1'b1;
               state_d     = ST_RESPOND;
            end else begin
               mem_read_d = 1'b1;
               mem_addr_d = addr;
               state_d    = ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            if (mem_ready) begin
               mem_write_d = 1'b0;
               st_dirty_en = 1'b1;
               st_dirty    = 1'b0;
               state_d     = ST_COMPARE;   // victim now clean; re-decide
            end
         end
         ST_ALLOCATE: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               st_line     = mem_rdata;
               st_line_en  = 1'b1;
               st_tag_en   = 1'b1;
               st_dirty_en = 1'b1;
               st_dirty    = 1'b0;
               state_d     = ST_COMPARE;   // re-compare is a guaranteed hit
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_wr_q     <= 1'b0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign rdata     = rdata_q;
   assign ready     = ready_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef L2_STAT_EN
   // refill marks that the current request already missed once, so the
   // post-writeback / post-fill re-compare is not counted again.
   logic        refill_q, refill_d;
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      refill_d   = refill_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == ST_IDLE) begin
         refill_d = 1'b0;
      end else if (state_q == ST_COMPARE) begin
         if (!refill_q) begin
            if (hit) begin
               if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
               if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
               refill_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refill_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         refill_q   <= refill_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_cache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_l2_cache
// Purpose  : Self-checking bench for l2_cache. A reference model (golden
//            memory image plus per-index tag/dirty bookkeeping) predicts the
//            L1 responses and the memory traffic; a responder process plays
//            main memory and checks each request, a monitor checks each
//            ready pulse. Directed scenarios are followed by random traffic.
// Options  : L2_STAT_EN - also checks hit_cnt / miss_cnt
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cache;

   localparam int LW = 128;
   localparam int AW = 28;
   localparam int IW = 3;
   localparam int NE = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [LW-1:0] wdata = '0;
   logic [LW-1:0] rdata;
   logic          ready;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
`ifdef L2_STAT_EN
   logic [15:0]   hit_cnt;
   logic [15:0]   miss_cnt;
`endif

   l2_cache dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read      (read),
      .write     (write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
`ifdef L2_STAT_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { bit is_wr; logic [AW-1:0] a; logic [LW-1:0] d; } mem_txn_t;
   typedef struct { bit is_wr; logic [LW-1:0] d; } resp_t;

   mem_txn_t      exp_mem[$];
   resp_t         exp_resp[$];
   logic [LW-1:0] gold [logic [AW-1:0]];   // value the L1 should observe
   logic [LW-1:0] dram [logic [AW-1:0]];   // contents of simulated memory
   bit            m_valid [NE];
   bit            m_dirty [NE];
   logic [AW-IW-1:0] m_tag [NE];
   int            n_chk = 0;
   int            n_fail = 0;
   int            n_hits = 0;
   int            n_miss = 0;
   bit            mem_hold = 1'b0;

   function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
      return {4{4'h5, a}};
   endfunction

   function automatic logic [LW-1:0] gold_rd(input logic [AW-1:0] a);
      return gold.exists(a) ? gold[a] : init_line(a);
   endfunction

   function automatic logic [LW-1:0] dram_rd(input logic [AW-1:0] a);
      return dram.exists(a) ? dram[a] : init_line(a);
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: checks each new request against the model, then
   // completes it after a random delay with a one-cycle mem_ready pulse.
   initial begin : responder
      bit       seen;
      int       dly;
      mem_txn_t t;
      logic [AW-1:0] cur_a;
      seen = 1'b0;
      dly = 0;
      cur_a = '0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (!rst_n) begin
            seen = 1'b0;
         end else if (mem_read || mem_write) begin
            check("mem_rw_exclusive", LW'(mem_read & mem_write), '0);
            if (!seen) begin
               seen = 1'b1;
               dly = $urandom_range(0, 3);
               cur_a = mem_addr;
               if (exp_mem.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL mem_unexpected: got wr=%0b addr %h, expected no memory request",
                           mem_write, mem_addr);
               end else begin
                  t = exp_mem.pop_front();
                  check("mem_kind", LW'(mem_write), LW'(t.is_wr));
                  check("mem_addr", LW'(mem_addr), LW'(t.a));
                  if (t.is_wr) check("mem_wdata", mem_wdata, t.d);
               end
            end
            if (!mem_hold) begin
               if (dly == 0) begin
                  check("mem_addr_stable", LW'(mem_addr), LW'(cur_a));
                  if (mem_write) dram[mem_addr] = mem_wdata;
                  else mem_rdata = dram_rd(mem_addr);
                  mem_ready = 1'b1;
                  seen = 1'b0;
               end else begin
                  dly--;
               end
            end
         end
      end
   end

   // Response monitor: every ready pulse must be expected and one cycle wide.
   initial begin : monitor
      resp_t r;
      bit    prev_ready;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && ready) begin
            check("ready_one_cycle", LW'(prev_ready), '0);
            if (exp_resp.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL ready_unexpected: got ready=1, expected no response");
            end else begin
               r = exp_resp.pop_front();
               if (!r.is_wr) check("rdata", rdata, r.d);
            end
         end
         prev_ready = rst_n && ready;
      end
   end

   task automatic do_req(input bit wr, input bit both, input logic [AW-1:0] a, input logic [LW-1:0] d);
      int idx;
      logic [AW-IW-1:0] tg;
      logic [AW-1:0] va;
      bit hit, fast;
      resp_t r;
      int cyc;
      idx = int'(a[IW-1:0]);
      tg  = a[AW-1:IW];
      va  = {m_tag[idx], a[IW-1:0]};
      hit = m_valid[idx] && (m_tag[idx] == tg);
      fast = hit || (wr && !m_dirty[idx]);
      if (!hit && m_dirty[idx]) exp_mem.push_back('{1'b1, va, gold_rd(va)});
      if (!hit && !wr) exp_mem.push_back('{1'b0, a, '0});
      r.is_wr = wr;
      r.d = gold_rd(a);
      exp_resp.push_back(r);
      if (hit) n_hits++; else n_miss++;
      if (wr) gold[a] = d;
      m_dirty[idx] = wr ? 1'b1 : (hit ? m_dirty[idx] : 1'b0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;

      @(negedge clk);
      read  = !wr || both;
      write = wr;
      addr  = a;
      wdata = d;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ready && cyc < 200);
      read  = 1'b0;
      write = 1'b0;
      if (!ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout: got no ready in %0d cycles for addr %h, expected a response", cyc, a);
         exp_resp.delete();
         exp_mem.delete();
      end else begin
         if (fast) check("hit_latency", LW'(cyc), LW'(2));
         check("mem_traffic_done", LW'(exp_mem.size()), '0);
      end
   endtask

   initial begin : stimulus
      int cyc;
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      gold[28'h0000010] = {32{4'hA}};
      dram[28'h0000010] = {32{4'hA}};

      repeat (3) @(negedge clk);
      check("rst_ready",     LW'(ready), '0);
      check("rst_rdata",     rdata, '0);
      check("rst_mem_read",  LW'(mem_read), '0);
      check("rst_mem_write", LW'(mem_write), '0);
      check("rst_mem_addr",  LW'(mem_addr), '0);
      check("rst_mem_wdata", mem_wdata, '0);
      rst_n = 1'b1;

      // Cold read, repeat hit, write hit, read-back.
      do_req(1'b0, 1'b0, 28'h0000010, '0);
      do_req(1'b0, 1'b0, 28'h0000010, '0);
      do_req(1'b1, 1'b0, 28'h0000010, 128'h1234);
      do_req(1'b0, 1'b0, 28'h0000010, '0);
      // Conflict with a dirty victim: writeback then fill.
      do_req(1'b0, 1'b0, 28'h0000018, '0);
      // Write miss over a clean victim, then a conflicting read evicts it.
      do_req(1'b1, 1'b0, 28'h0000020, {4{32'hCAFE_F00D}});
      do_req(1'b0, 1'b0, 28'h0000010, '0);
      // Simultaneous read and write: write takes effect.
      do_req(1'b1, 1'b1, 28'h0000010, {4{32'h0BAD_BEEF}});
      do_req(1'b0, 1'b0, 28'h0000010, '0);

      // Reset while a fill is outstanding.
      mem_hold = 1'b1;
      exp_mem.push_back('{1'b0, 28'h0000021, '0});
      @(negedge clk);
      read = 1'b1;
      addr = 28'h0000021;
      cyc = 0;
      while (!mem_read && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("alloc_reached", LW'(mem_read), LW'(1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_read", LW'(mem_read), '0);
      check("rst_mid_ready",    LW'(ready), '0);
      check("rst_mid_rdata",    rdata, '0);
      read = 1'b0;
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      gold = dram;           // dirty lines held only in the cache are lost
      exp_mem.delete();
      exp_resp.delete();
      n_hits = 0;
      n_miss = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_hold = 1'b0;
      do_req(1'b0, 1'b0, 28'h0000010, '0);

      // Random traffic over a small address pool to force conflicts.
      for (int n = 0; n < 300; n++) begin
         logic [AW-1:0] ra;
         bit rw;
         ra = AW'($urandom_range(0, 31));
         rw = 1'($urandom_range(0, 1));
         do_req(rw, 1'($urandom_range(0, 7) == 0), ra,
                {$urandom, $urandom, $urandom, $urandom});
      end

      repeat (4) @(negedge clk);
      check("no_pending_resp", LW'(exp_resp.size()), '0);
`ifdef L2_STAT_EN
      check("hit_cnt",  LW'(hit_cnt),  LW'(n_hits > 65535 ? 65535 : n_hits));
      check("miss_cnt", LW'(miss_cnt), LW'(n_miss > 65535 ? 65535 : n_miss));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
